// File: rtl/rv_fetch_pkg.sv
// Shared encodings, reset constants and counter arithmetic for the fetch predictor.
// Pure definitions: no latency, no flow control.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0004;

  // Saturating 2-bit counter step, clamped at SNT and ST.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != ST) res = cnt + 2'd1;
    end else begin
      if (cnt != SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_table.sv
// BHT + direct-mapped BTB: combinational lookup, writes land on the next posedge.
// Lookup and same-index update in one cycle read the pre-update state; no backpressure.
import rv_fetch_pkg::*;

module branch_table #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] rd_pc,
  output logic        rd_hit,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        upd_valid,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:2] upd_pc,
  input  logic [31:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [1:0]       bht_q        [ENTRIES];
  logic [1:0]       bht_d        [ENTRIES];
  logic             btb_valid_q  [ENTRIES];
  logic             btb_valid_d  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0] btb_tag_d    [ENTRIES];
  logic [31:0]      btb_target_q [ENTRIES];
  logic [31:0]      btb_target_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];

  always_comb begin
    rd_hit    = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_pc[31:IDX_W+2]);
    rd_taken  = bht_q[rd_idx][1];
    rd_target = btb_target_q[rd_idx];
  end

  always_comb begin
    bht_d        = bht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid) begin
      // A not-taken jump (JALR with no link) carries no direction information.
      if (upd_is_branch) begin
        bht_d[upd_idx] = sat_update(bht_q[upd_idx], upd_taken);
      end else if (upd_taken) begin
        bht_d[upd_idx] = ST;
      end
      if (upd_taken) begin
        btb_valid_d[upd_idx]  = 1'b1;
        btb_tag_d[upd_idx]    = upd_pc[31:IDX_W+2];
        btb_target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i]        <= WNT;
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else begin
      bht_q        <= bht_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// PC register, next-PC selection and IF register; IF outputs trail imem_addr by one cycle.
// stall_pipe freezes PC and IF outputs; trap/redirect override stall and squash the fetch.
import rv_fetch_pkg::*;

module fetch_predictor #(
  parameter int          IDX_W       = 6,
  parameter logic [31:0] RESET_PC    = rv_fetch_pkg::RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = rv_fetch_pkg::TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_pipe,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic        resolve_valid,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_pc,
  input  logic [31:0] resolve_target,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_IF,
  output logic        prediction_IF,
  output logic        valid_IF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic        pred_if_q, pred_if_d;
  logic        valid_if_q, valid_if_d;

  logic        bt_hit;
  logic        bt_taken;
  logic [31:0] bt_target;
  logic        pred;
  logic        unused_low_bits;

  assign unused_low_bits = ^{redirect_pc[1:0], resolve_pc[1:0]};

  branch_table #(.IDX_W(IDX_W)) u_branch_table (
    .clk           (clk),
    .reset         (reset),
    .rd_pc         (pc_q[31:2]),
    .rd_hit        (bt_hit),
    .rd_taken      (bt_taken),
    .rd_target     (bt_target),
    .upd_valid     (resolve_valid),
    .upd_is_branch (resolve_is_branch),
    .upd_taken     (resolve_taken),
    .upd_pc        (resolve_pc[31:2]),
    .upd_target    (resolve_target)
  );

  assign pred = bt_hit & bt_taken;

  always_comb begin
    pc_d       = pc_q + 32'd4;
    pc_if_d    = pc_if_q;
    pred_if_d  = pred_if_q;
    valid_if_d = valid_if_q;
    if (trap_valid) begin
      pc_d       = TRAP_VECTOR;
      valid_if_d = 1'b0;
    end else if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      valid_if_d = 1'b0;
    end else if (stall_pipe) begin
      pc_d = pc_q;
    end else begin
      if (pred) pc_d = bt_target;
      pc_if_d    = pc_q;
      pred_if_d  = pred;
      valid_if_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pc_if_q    <= '0;
      pred_if_q  <= 1'b0;
      valid_if_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_if_q    <= pc_if_d;
      pred_if_q  <= pred_if_d;
      valid_if_q <= valid_if_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc_IF         = pc_if_q;
  assign prediction_IF = pred_if_q;
  assign valid_IF      = valid_if_q;

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor: straight-line fetch, training, redirect/stall/trap priority, aliasing, saturation.
module tb_fetch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_pipe, redirect_valid, trap_valid;
  logic [31:0] redirect_pc;
  logic        resolve_valid, resolve_is_branch, resolve_taken;
  logic [31:0] resolve_pc, resolve_target;
  logic [31:0] imem_addr, pc_IF;
  logic        prediction_IF, valid_IF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_predictor dut (
    .clk               (clk),
    .reset             (reset),
    .stall_pipe        (stall_pipe),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .trap_valid        (trap_valid),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_pc        (resolve_pc),
    .resolve_target    (resolve_target),
    .imem_addr         (imem_addr),
    .pc_IF             (pc_IF),
    .prediction_IF     (prediction_IF),
    .valid_IF          (valid_IF)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall_pipe        = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    trap_valid        = 1'b0;
    resolve_valid     = 1'b0;
    resolve_is_branch = 1'b0;
    resolve_taken     = 1'b0;
    resolve_pc        = '0;
    resolve_target    = '0;
  endtask

  task automatic resolve(input logic is_br, input logic taken, input logic [31:0] rpc, input logic [31:0] tgt);
    resolve_valid     = 1'b1;
    resolve_is_branch = is_br;
    resolve_taken     = taken;
    resolve_pc        = rpc;
    resolve_target    = tgt;
    tick();
    idle();
  endtask

  task automatic redirect(input logic [31:0] rpc);
    redirect_valid = 1'b1;
    redirect_pc    = rpc;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pcif",  pc_IF, 32'h0);
    check("rst_pred",  {31'd0, prediction_IF}, 32'd0);
    check("rst_valid", {31'd0, valid_IF}, 32'd0);
    reset = 1'b1;

    // Straight-line fetch
    tick();
    check("seq1_addr",  imem_addr, 32'h4);
    check("seq1_valid", {31'd0, valid_IF}, 32'd1);
    check("seq1_pcif",  pc_IF, 32'h0);
    check("seq1_pred",  {31'd0, prediction_IF}, 32'd0);
    tick();
    check("seq2_addr", imem_addr, 32'h8);
    tick();
    check("seq3_addr", imem_addr, 32'hC);
    check("seq3_pcif", pc_IF, 32'h8);

    // Train loop branch at 0x20 -> 0x10; pc runs 0xC -> 0x14 meanwhile
    resolve(1'b1, 1'b1, 32'h20, 32'h10);
    resolve(1'b1, 1'b1, 32'h20, 32'h10);
    check("train_addr", imem_addr, 32'h14);
    tick();
    tick();
    tick();
    check("loop_fetch", imem_addr, 32'h20);
    tick();
    check("loop_pred_addr", imem_addr, 32'h10);
    check("loop_pcif",      pc_IF, 32'h20);
    check("loop_pred",      {31'd0, prediction_IF}, 32'd1);

    // Mispredict recovery with counter decrement 11 -> 10
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h24;
    resolve_valid     = 1'b1;
    resolve_is_branch = 1'b1;
    resolve_taken     = 1'b0;
    resolve_pc        = 32'h20;
    tick();
    idle();
    check("misp_addr",  imem_addr, 32'h24);
    check("misp_valid", {31'd0, valid_IF}, 32'd0);
    check("misp_pcif",  pc_IF, 32'h20);
    tick();
    check("misp2_addr",  imem_addr, 32'h28);
    check("misp2_valid", {31'd0, valid_IF}, 32'd1);
    check("misp2_pcif",  pc_IF, 32'h24);
    redirect(32'h20);
    check("wt_fetch", imem_addr, 32'h20);
    tick();
    check("wt_pred_addr", imem_addr, 32'h10);
    check("wt_pred",      {31'd0, prediction_IF}, 32'd1);

    // Stall freezes everything; redirect overrides stall
    stall_pipe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  imem_addr, 32'h10);
      check("stall_pcif",  pc_IF, 32'h20);
      check("stall_valid", {31'd0, valid_IF}, 32'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    idle();
    check("stall_redir_addr",  imem_addr, 32'h100);
    check("stall_redir_valid", {31'd0, valid_IF}, 32'd0);

    // Trap beats redirect
    trap_valid = 1'b1;
    redirect(32'h102);
    check("trap_addr",  imem_addr, 32'h4);
    check("trap_valid", {31'd0, valid_IF}, 32'd0);
    tick();
    check("post_trap_addr", imem_addr, 32'h8);
    check("post_trap_pcif", pc_IF, 32'h4);

    // Misaligned redirect is force-aligned
    redirect(32'h102);
    check("align_addr", imem_addr, 32'h100);

    // Aliasing: 0x120 shares index with 0x20 but not the tag
    redirect(32'h120);
    check("alias_fetch", imem_addr, 32'h120);
    tick();
    check("alias_addr", imem_addr, 32'h124);
    check("alias_pred", {31'd0, prediction_IF}, 32'd0);

    // Four not-taken from 10 must clamp at 00, not wrap to a taken state
    for (int i = 0; i < 4; i++) resolve(1'b1, 1'b0, 32'h20, 32'h10);
    redirect(32'h20);
    tick();
    check("clamp_addr", imem_addr, 32'h24);
    check("clamp_pred", {31'd0, prediction_IF}, 32'd0);
    // One taken from 00 reaches 01: still not predicted
    resolve(1'b1, 1'b1, 32'h20, 32'h10);
    redirect(32'h20);
    tick();
    check("wnt_addr", imem_addr, 32'h24);

    // JAL sets strong taken; JALR reported not-taken leaves tables alone
    resolve(1'b0, 1'b1, 32'h40, 32'h80);
    resolve(1'b0, 1'b0, 32'h60, 32'h90);
    redirect(32'h40);
    tick();
    check("jal_addr", imem_addr, 32'h80);
    check("jal_pred", {31'd0, prediction_IF}, 32'd1);
    redirect(32'h60);
    tick();
    check("jalr_nt_addr", imem_addr, 32'h64);

    // Same-cycle lookup and update: lookup sees pre-update state
    redirect(32'h60);
    resolve(1'b0, 1'b1, 32'h60, 32'hA0);
    check("rbw_addr", imem_addr, 32'h64);
    redirect(32'h60);
    tick();
    check("rbw_after", imem_addr, 32'hA0);

    // Reset mid-operation discards pending redirect and training
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    resolve_valid  = 1'b1;
    resolve_is_branch = 1'b0;
    resolve_taken  = 1'b1;
    resolve_pc     = 32'h0;
    resolve_target = 32'h300;
    tick();
    idle();
    reset = 1'b1;
    check("rst2_addr",  imem_addr, 32'h0);
    check("rst2_valid", {31'd0, valid_IF}, 32'd0);
    tick();
    check("rst2_seq", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
